// File: rtl/mips_run_ctrl.sv
// ---------------------------------------------------------------------------
// mips_run_ctrl
//   Run controller for a MIPS core under test. It holds the core in reset
//   for RESET_CYCLES cycles, lets it run, and then decides the outcome. A
//   halt is declared when pc stays unchanged for HALT_REPEAT consecutive
//   RUN cycles. A timeout is declared when the RUN-cycle budget MAX_CYCLES
//   is exhausted. The result is a pass when the last write to register
//   SIG_REG carried SIG_VALUE.
//
// Ports
//   clk         in   1          single clock, all state changes on rising edge
//   reset       in   1          synchronous active-high reset
//   pc          in   PC_WIDTH   core program counter
//   reg_we      in   1          core register-file write enable
//   reg_waddr   in   5          core register-file write address
//   reg_wdata   in   32         core register-file write data
//   cpu_reset   out  1          reset to the core (high in HOLD)
//   running     out  1          high in RUN
//   done        out  1          high in HALTED or TIMEOUT
//   pass        out  1          high in HALTED when the signature matched
//   timeout     out  1          high in TIMEOUT
//   cycle_count out  CNT_WIDTH  RUN cycles elapsed, saturating
// ---------------------------------------------------------------------------
module mips_run_ctrl #(
    parameter int          PC_WIDTH     = 32,
    parameter int          CNT_WIDTH    = 32,
    parameter int          RESET_CYCLES = 4,
    parameter int          MAX_CYCLES   = 600,
    parameter int          HALT_REPEAT  = 3,
    parameter int          SIG_REG      = 2,
    parameter logic [31:0] SIG_VALUE    = 32'h00000001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 reg_we,
    input  logic [4:0]           reg_waddr,
    input  logic [31:0]          reg_wdata,
    output logic                 cpu_reset,
    output logic                 running,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int RUN_W  = $clog2(HALT_REPEAT + 1);

    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [RUN_W-1:0]     HALT_LEN  = RUN_W'(HALT_REPEAT);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_CYCLES);
    localparam logic [4:0]           SIG_ADDR  = 5'(SIG_REG);

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        HALTED,
        TIMEOUT
    } state_t;

    state_t               state, state_d;
    logic [HOLD_W-1:0]    hold_cnt, hold_cnt_d;
    logic [RUN_W-1:0]     run_len, run_len_d;
    logic [CNT_WIDTH-1:0] cycle_count_d;
    logic                 sig_seen, sig_seen_d;
    logic                 sig_ok, sig_ok_d;
    logic [PC_WIDTH-1:0]  prev_pc;

    logic cpu_reset_d, running_d, done_d, pass_d, timeout_d;

    // Next state and next registered outputs.
    always_comb begin
        state_d       = state;
        hold_cnt_d    = hold_cnt;
        run_len_d     = run_len;
        cycle_count_d = cycle_count;
        sig_seen_d    = sig_seen;
        sig_ok_d      = sig_ok;

        case (state)
            HOLD: begin
                hold_cnt_d = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (cycle_count != '1) begin
                    cycle_count_d = cycle_count + 1'b1;
                end

                // run_len is still 0 on the first RUN cycle, so prev_pc
                // (left over from HOLD) is never trusted there.
                if (run_len == '0 || pc != prev_pc) begin
                    run_len_d = RUN_W'(1);
                end else begin
                    run_len_d = run_len + 1'b1;
                end

                // Captured combinationally so a signature write on the
                // halting cycle is already reflected in pass.
                if (reg_we && reg_waddr == SIG_ADDR) begin
                    sig_seen_d = 1'b1;
                    sig_ok_d   = (reg_wdata == SIG_VALUE);
                end

                // Halt wins over a timeout that qualifies on the same edge.
                if (run_len_d == HALT_LEN) begin
                    state_d = HALTED;
                end else if (cycle_count_d == MAX_CNT) begin
                    state_d = TIMEOUT;
                end
            end

            default: begin
                state_d = state;
            end
        endcase

        // Outputs are decoded from the next state and registered below.
        cpu_reset_d = (state_d == HOLD);
        running_d   = (state_d == RUN);
        done_d      = (state_d == HALTED) || (state_d == TIMEOUT);
        pass_d      = (state_d == HALTED) && sig_seen_d && sig_ok_d;
        timeout_d   = (state_d == TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            run_len     <= '0;
            cycle_count <= '0;
            sig_seen    <= 1'b0;
            sig_ok      <= 1'b0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_d;
            hold_cnt    <= hold_cnt_d;
            run_len     <= run_len_d;
            cycle_count <= cycle_count_d;
            sig_seen    <= sig_seen_d;
            sig_ok      <= sig_ok_d;
            cpu_reset   <= cpu_reset_d;
            running     <= running_d;
            done        <= done_d;
            pass        <= pass_d;
            timeout     <= timeout_d;
        end
    end

    // Previous-cycle pc; only consulted after the first RUN cycle.
    always_ff @(posedge clk) begin
        prev_pc <= pc;
    end

endmodule
